// File: rtl/cla_multiword_seq.sv
// Multi-word adder: one 12-bit CLA slice reused LSB-first, carry chained through a register.
// Latency WORDS+1 cycles start->done; start is ignored while busy (no queuing).

module cla12 (
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  input  logic        cin_i,
  output logic [11:0] sum_o,
  output logic        cout_o
);
  logic [11:0] p, g, c;
  logic [2:0]  gp, gg;
  logic [3:0]  gc;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Second level: carries into each 4-bit group from group propagate/generate.
  assign gc[0] = cin_i;
  assign gc[1] = gg[0] | (gp[0] & cin_i);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin_i);

  for (genvar k = 0; k < 3; k++) begin : g_grp
    localparam int B = 4 * k;
    assign gp[k] = &p[B+3:B];
    assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);
  end

  assign sum_o  = p ^ c;
  assign cout_o = gc[3];
endmodule

module cla_multiword_seq #(
  parameter int SLICE_W = 12,  // must stay 12: the slice is cla12
  parameter int WORDS   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SLICE_W*WORDS-1:0]   a,
  input  logic [SLICE_W*WORDS-1:0]   b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*WORDS-1:0]   sum,
  output logic                       cout,
  output logic                       ovf
);
  localparam int N     = SLICE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [SLICE_W-1:0] slice_sum;
  logic             slice_cout;

  cla12 u_slice (
    .a_i    (a_q[idx_q*SLICE_W +: SLICE_W]),
    .b_i    (b_q[idx_q*SLICE_W +: SLICE_W]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        idx_d   = '0;
        sum_d   = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST) begin
          // On the last slice the slice MSB is the result sign bit.
          cout_d  = slice_cout;
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (slice_sum[SLICE_W-1] != a_q[N-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed-vector bench for cla_multiword_seq with WORDS=4 (48-bit operands).
module tb_cla_multiword_seq;
  logic        clk = 1'b0;
  logic        rst_n, start, cin;
  logic [47:0] a, b;
  logic        busy, done, cout, ovf;
  logic [47:0] sum;

  int vectors = 0;
  int miscompares = 0;

  cla_multiword_seq #(.SLICE_W(12), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Drives one start pulse and waits (bounded) for done; lat = negedges from start to done, -1 on timeout.
  task automatic do_add(input logic [47:0] av, input logic [47:0] bv, input logic cv,
                        output logic [47:0] s, output logic co, output logic ov, output int lat);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = i; break; end
    end
    s = sum; co = cout; ov = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 48'hFFFF_FFFF_FFFF; b = 48'h1234; cin = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, cout, ovf} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags got %b exp 0000", {busy, done, cout, ovf});
    end
    vectors++;
    if (sum !== 48'd0) begin miscompares++; $display("FAIL reset_sum got %h exp 0", sum); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_zero();
    logic [47:0] s; logic co, ov; int lat;
    do_add(48'd0, 48'd0, 1'b0, s, co, ov, lat);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL zero_latency got %0d exp 5", lat); end
    vectors++;
    if ({s, co, ov} !== 50'd0) begin miscompares++; $display("FAIL zero_result got %h/%b/%b exp 0/0/0", s, co, ov); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL zero_busy_in_done got %b exp 1", busy); end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL zero_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_carry_boundary();
    logic [47:0] s; logic co, ov; int lat;
    do_add(48'h000000000FFF, 48'h1, 1'b0, s, co, ov, lat);
    vectors++;
    if ({s, co, ov} !== {48'h000000001000, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL slice_boundary got %h/%b/%b exp 000000001000/0/0", s, co, ov);
    end
  endtask

  task automatic test_ripple();
    logic [47:0] s; logic co, ov; int lat;
    do_add(48'hFFFFFFFFFFFF, 48'h0, 1'b1, s, co, ov, lat);
    vectors++;
    if ({s, co, ov} !== {48'h0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL full_ripple got %h/%b/%b exp 0/1/0", s, co, ov);
    end
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL ripple_latency got %0d exp 5", lat); end
  endtask

  task automatic test_overflow();
    logic [47:0] s; logic co, ov; int lat;
    do_add(48'h7FFFFFFFFFFF, 48'h1, 1'b0, s, co, ov, lat);
    vectors++;
    if ({s, co, ov} !== {48'h800000000000, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL ovf_pos got %h/%b/%b exp 800000000000/0/1", s, co, ov);
    end
    do_add(48'h800000000000, 48'h800000000000, 1'b0, s, co, ov, lat);
    vectors++;
    if ({s, co, ov} !== {48'h0, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL ovf_neg got %h/%b/%b exp 0/1/1", s, co, ov);
    end
  endtask

  task automatic test_sweep();
    logic [47:0] ta[4] = '{48'd15, 48'd12, 48'd7, 48'd11};
    logic [47:0] tb[4] = '{48'd1795, 48'd14, 48'd353, 48'd3311};
    logic [47:0] te[4] = '{48'd1810, 48'd26, 48'd360, 48'd3322};
    logic [47:0] s; logic co, ov; int lat;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        do_add(ta[i], tb[i], c[0], s, co, ov, lat);
        vectors++;
        if ({s, co, ov} !== {te[i] + 48'(c), 1'b0, 1'b0}) begin
          miscompares++;
          $display("FAIL sweep_%0d_cin%0d got %0d/%b/%b exp %0d/0/0", i, c, s, co, ov, te[i] + 48'(c));
        end
      end
    end
    do_add(48'hABC123456789, 48'h123456789ABC, 1'b0, s, co, ov, lat);
    vectors++;
    if ({s, co, ov} !== {48'hBDF579BE0245, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL mixed_word got %h/%b/%b exp BDF579BE0245/0/0", s, co, ov);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a = 48'd100; b = 48'd23; cin = 1'b0; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 2) begin start = 1'b1; a = 48'h5555; b = 48'h7; cin = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL ignore_latency got %0d exp 5", lat); end
    vectors++;
    if ({sum, cout} !== {48'd123, 1'b0}) begin
      miscompares++; $display("FAIL ignore_result got %0d/%b exp 123/0", sum, cout);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_queue got busy=%b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    @(negedge clk);
    a = 48'd1; b = 48'd2; cin = 1'b0; start = 1'b1;
    first = -1; second = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done && first < 0) begin
        first = i;
        vectors++;
        if (sum !== 48'd3) begin miscompares++; $display("FAIL b2b_first got %0d exp 3", sum); end
        a = 48'd5;
      end else if (done) begin
        second = i; start = 1'b0; break;
      end
    end
    start = 1'b0;
    vectors++;
    if (second - first !== 6 || first !== 5) begin
      miscompares++; $display("FAIL b2b_spacing got first=%0d gap=%0d exp 5 and 6", first, second - first);
    end
    vectors++;
    if (sum !== 48'd7) begin miscompares++; $display("FAIL b2b_second got %0d exp 7", sum); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [47:0] s; logic co, ov; int lat;
    bit saw_done;
    @(negedge clk);
    a = 48'hFFFFFFFFFFFF; b = 48'h1; cin = 1'b0; start = 1'b1;
    repeat (3) begin @(negedge clk); start = 1'b0; end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, cout, ovf} !== 4'b0000 || sum !== 48'd0) begin
      miscompares++; $display("FAIL mid_reset got busy=%b done=%b sum=%h exp 0 0 0", busy, done, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin @(negedge clk); if (done) saw_done = 1'b1; end
    vectors++;
    if (saw_done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_no_done got 1 exp 0"); end
    do_add(48'h000000FFF000, 48'h000000001000, 1'b1, s, co, ov, lat);
    vectors++;
    if ({s, co, ov} !== {48'h000001000001, 1'b0, 1'b0} || lat !== 5) begin
      miscompares++; $display("FAIL after_reset got %h/%b/%b lat %0d exp 000001000001/0/0 lat 5", s, co, ov, lat);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry_boundary();
    test_ripple();
    test_overflow();
    test_sweep();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
